// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// EX operand forwarding select codes.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DWAIT = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Combinational hazard detection (load-use / RAW-without-forwarding) and
// EX operand forwarding selection.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W  = 3,
    parameter int FWD_EN = 1
) (
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_use,
    input  logic             i_id_rt_use,
    input  logic             i_ex_valid,
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_wen,
    input  logic             i_ex_load,
    input  logic             i_mem_valid,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_wen,
    input  logic             i_mem_load,
    input  logic             i_wb_valid,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_wb_wen,
    output logic             o_id_stall,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel
);

    logic w_ex_hit, w_mem_hit, w_wb_hit, w_load_use, w_raw;

    function automatic logic reads(input logic [REG_W-1:0] rd);
        return (i_id_rs_use && i_id_rs == rd) || (i_id_rt_use && i_id_rt == rd);
    endfunction

    always_comb begin
        w_ex_hit   = i_id_valid && i_ex_valid  && i_ex_wen  && reads(i_ex_rd);
        w_mem_hit  = i_id_valid && i_mem_valid && i_mem_wen && reads(i_mem_rd);
        w_wb_hit   = i_id_valid && i_wb_valid  && i_wb_wen  && reads(i_wb_rd);
        w_load_use = w_ex_hit && i_ex_load;
        w_raw      = w_ex_hit || w_mem_hit || w_wb_hit;
        o_id_stall = (FWD_EN != 0) ? w_load_use : w_raw;
    end

    // Loads in EX/MEM have no result yet; MEM/WB is the next-newest source.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        if (FWD_EN == 0)
            return FWD_RF;
        else if (i_mem_valid && i_mem_wen && !i_mem_load && i_mem_rd == src)
            return FWD_MEM;
        else if (i_wb_valid && i_wb_wen && i_wb_rd == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign o_fwd_a_sel = fwd_sel(i_ex_rs);
    assign o_fwd_b_sel = fwd_sel(i_ex_rt);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with halt/dmem-wait
// FSM and saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16,
    parameter int FWD_EN = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_use,
    input  logic             i_id_rt_use,
    input  logic             i_ex_valid,
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_wen,
    input  logic             i_ex_load,
    input  logic             i_ex_redirect,
    input  logic             i_mem_valid,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_wen,
    input  logic             i_mem_load,
    input  logic             i_mem_req,
    input  logic             i_mem_done,
    input  logic             i_imem_done,
    input  logic             i_wb_valid,
    input  logic [REG_W-1:0] i_wb_rd,
    input  logic             i_wb_wen,
    input  logic             i_wb_halt,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_t           r_state, w_state_nxt;
    logic             w_id_stall, w_dmem_wait, w_redirect_fire;
    logic [1:0]       w_fwd_a, w_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    hazard_fwd_unit #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_hfu (
        .i_id_valid (i_id_valid),  .i_id_rs    (i_id_rs),    .i_id_rt     (i_id_rt),
        .i_id_rs_use(i_id_rs_use), .i_id_rt_use(i_id_rt_use),
        .i_ex_valid (i_ex_valid),  .i_ex_rs    (i_ex_rs),    .i_ex_rt     (i_ex_rt),
        .i_ex_rd    (i_ex_rd),     .i_ex_wen   (i_ex_wen),   .i_ex_load   (i_ex_load),
        .i_mem_valid(i_mem_valid), .i_mem_rd   (i_mem_rd),   .i_mem_wen   (i_mem_wen),
        .i_mem_load (i_mem_load),
        .i_wb_valid (i_wb_valid),  .i_wb_rd    (i_wb_rd),    .i_wb_wen    (i_wb_wen),
        .o_id_stall (w_id_stall),  .o_fwd_a_sel(w_fwd_a),    .o_fwd_b_sel (w_fwd_b)
    );

    assign w_dmem_wait = i_mem_valid && i_mem_req && !i_mem_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_redirect_fire = 1'b0;
        o_pc_en         = 1'b1;
        o_ifid_en       = 1'b1;
        o_idex_en       = 1'b1;
        o_exmem_en      = 1'b1;
        o_memwb_en      = 1'b1;
        o_ifid_flush    = 1'b0;
        o_idex_flush    = 1'b0;
        o_exmem_flush   = 1'b0;
        if (i_rst) begin
            {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = '0;
            {o_ifid_flush, o_idex_flush, o_exmem_flush}             = '1;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_HALT) begin
            {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = '0;
        end else begin
            // A pending data access freezes everything; hazards re-present later.
            if (w_dmem_wait) begin
                {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en} = '0;
                w_state_nxt = ST_DWAIT;
            end else begin
                w_state_nxt = ST_RUN;
                if (i_ex_redirect && i_ex_valid) begin
                    o_ifid_flush    = 1'b1;
                    o_idex_flush    = 1'b1;
                    w_redirect_fire = 1'b1;
                end else if (w_id_stall) begin
                    o_pc_en      = 1'b0;
                    o_ifid_en    = 1'b0;
                    o_idex_flush = 1'b1;
                end else if (!i_imem_done) begin
                    o_pc_en      = 1'b0;
                    o_ifid_flush = 1'b1;
                end
            end
            if (i_wb_halt) begin
                o_pc_en     = 1'b0;
                o_memwb_en  = 1'b0;
                w_state_nxt = ST_HALT;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_state != ST_HALT && (!o_pc_en || !o_ifid_en) && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect_fire && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign o_fwd_a_sel = i_rst ? FWD_RF : w_fwd_a;
    assign o_fwd_b_sel = i_rst ? FWD_RF : w_fwd_b;
    assign o_halted    = (r_state == ST_HALT);
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (CNT_W=4 so saturation is reachable).
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 3;
    localparam int CNT_W = 4;

    logic clk = 1'b0, rst;
    logic id_valid, id_rs_use, id_rt_use;
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic ex_valid, ex_wen, ex_load, ex_redirect;
    logic mem_valid, mem_wen, mem_load, mem_req, mem_done, imem_done;
    logic wb_valid, wb_wen, wb_halt;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, halted;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .FWD_EN(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_rs_use(id_rs_use), .i_id_rt_use(id_rt_use),
        .i_ex_valid(ex_valid), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_rd(ex_rd),
        .i_ex_wen(ex_wen), .i_ex_load(ex_load), .i_ex_redirect(ex_redirect),
        .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_wen(mem_wen),
        .i_mem_load(mem_load), .i_mem_req(mem_req), .i_mem_done(mem_done),
        .i_imem_done(imem_done),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_wen(wb_wen), .i_wb_halt(wb_halt),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en),
        .o_exmem_en(exmem_en), .o_memwb_en(memwb_en),
        .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush), .o_exmem_flush(exmem_flush),
        .o_fwd_a_sel(fwd_a), .o_fwd_b_sel(fwd_b), .o_halted(halted),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    typedef struct {
        string            name;
        logic [4:0]       en;
        logic [2:0]       fl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             hlt;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0, n_fail = 0;
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0;
    logic m_halted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_use = 0; id_rt_use = 0;
        ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_wen = 0; ex_load = 0;
        ex_redirect = 0;
        mem_valid = 0; mem_rd = 0; mem_wen = 0; mem_load = 0; mem_req = 0; mem_done = 0;
        imem_done = 1;
        wb_valid = 0; wb_rd = 0; wb_wen = 0; wb_halt = 0;
    endtask

    // Expectation pushed with the stimulus, popped and compared at the negedge.
    task automatic step(input string name, input logic [4:0] en, input logic [2:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input bit rdr);
        exp_t e, o;
        e.name = name; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
        e.hlt = m_halted; e.sc = m_stall; e.fc = m_flush;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk({o.name, ".en"},    32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(o.en));
        chk({o.name, ".flush"}, 32'({ifid_flush, idex_flush, exmem_flush}), 32'(o.fl));
        chk({o.name, ".fwd_a"}, 32'(fwd_a), 32'(o.fa));
        chk({o.name, ".fwd_b"}, 32'(fwd_b), 32'(o.fb));
        chk({o.name, ".halted"}, 32'(halted), 32'(o.hlt));
        chk({o.name, ".stall_cnt"}, 32'(stall_cnt), 32'(o.sc));
        chk({o.name, ".flush_cnt"}, 32'(flush_cnt), 32'(o.fc));
        if (!rst) begin
            if (!m_halted && (!en[4] || !en[3]) && m_stall != '1) m_stall++;
            if (rdr && m_flush != '1) m_flush++;
            if (wb_halt) m_halted = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; idle();
        // Forwarding match present during reset must still read as 00.
        mem_valid = 1; mem_wen = 1; mem_rd = 2; ex_rs = 2;
        step("reset", 5'b00000, 3'b111, 2'b00, 2'b00, 0);
        rst = 0; idle();
        step("idle", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

        // Load-use on r3, then bubble, then forwarding from MEM/WB.
        ex_valid = 1; ex_load = 1; ex_wen = 1; ex_rd = 3;
        id_valid = 1; id_rs = 3; id_rs_use = 1;
        step("lu_stall", 5'b00111, 3'b010, 2'b00, 2'b00, 0);
        idle();
        id_valid = 1; id_rs = 3; id_rs_use = 1;
        mem_valid = 1; mem_rd = 3; mem_wen = 1; mem_load = 1;
        step("lu_bubble", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
        idle();
        ex_valid = 1; ex_rs = 3; wb_valid = 1; wb_rd = 3; wb_wen = 1;
        mem_valid = 1; mem_rd = 3; mem_wen = 1; mem_load = 1;
        step("lu_fwd", 5'b11111, 3'b000, 2'b01, 2'b00, 0);
        idle();
        // rt matches the load but is not read -> no stall.
        ex_valid = 1; ex_load = 1; ex_wen = 1; ex_rd = 4;
        id_valid = 1; id_rt = 4; id_rt_use = 0; id_rs = 1; id_rs_use = 1;
        step("lu_rt_unused", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

        // Newest producer wins; register 0 is an ordinary register.
        idle();
        ex_valid = 1; ex_rs = 2; ex_rt = 2;
        mem_valid = 1; mem_rd = 2; mem_wen = 1; wb_valid = 1; wb_rd = 2; wb_wen = 1;
        step("fwd_newest", 5'b11111, 3'b000, 2'b10, 2'b10, 0);
        ex_rt = 5; wb_rd = 5;
        step("fwd_mix", 5'b11111, 3'b000, 2'b10, 2'b01, 0);
        mem_valid = 0; wb_rd = 2;
        step("fwd_memvalid0", 5'b11111, 3'b000, 2'b01, 2'b00, 0);
        idle();
        ex_rs = 0; ex_rt = 0; wb_valid = 1; wb_rd = 0; wb_wen = 1;
        step("fwd_r0", 5'b11111, 3'b000, 2'b01, 2'b01, 0);

        // Dmem wait freezes and masks a redirect, then redirect fires on mem_done.
        idle();
        mem_valid = 1; mem_req = 1; mem_done = 0; ex_valid = 1; ex_redirect = 1;
        for (int i = 0; i < 3; i++)
            step($sformatf("dwait%0d", i), 5'b00000, 3'b000, 2'b00, 2'b00, 0);
        mem_done = 1;
        step("dwait_done", 5'b11111, 3'b110, 2'b00, 2'b00, 1);
        idle();
        step("post_dwait", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

        // Redirect beats load-use and imem wait.
        ex_valid = 1; ex_redirect = 1; ex_load = 1; ex_wen = 1; ex_rd = 6;
        id_valid = 1; id_rs = 6; id_rs_use = 1; imem_done = 0;
        step("rdr_prio", 5'b11111, 3'b110, 2'b00, 2'b00, 1);
        idle(); imem_done = 0;
        step("imem_wait", 5'b01111, 3'b100, 2'b00, 2'b00, 0);

        // Saturation of the 4-bit stall counter.
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), 5'b01111, 3'b100, 2'b00, 2'b00, 0);
        idle();
        step("sat_hold", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

        // Halt: wb_halt cycle holds MEM/WB and PC, then everything frozen.
        wb_valid = 1; wb_halt = 1;
        step("halt_wb", 5'b01110, 3'b000, 2'b00, 2'b00, 0);
        idle(); ex_valid = 1; ex_redirect = 1; imem_done = 0;
        step("halted0", 5'b00000, 3'b000, 2'b00, 2'b00, 0);
        step("halted1", 5'b00000, 3'b000, 2'b00, 2'b00, 0);

        // Asynchronous reset mid-cycle returns to RUN.
        idle(); #2; rst = 1;
        m_stall = '0; m_flush = '0; m_halted = 1'b0;
        step("rst_async", 5'b00000, 3'b111, 2'b00, 2'b00, 0);
        rst = 0;
        step("after_rst", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
